// File: rtl/exu_regalu_if.sv
// Execute-unit datapath bus: GPR read/write ports plus ALU opcode, operands and result.
// Latency: carries purely combinational reads/ALU results; writes land on the clock edge.
// Backpressure: none; the datapath accepts every access each cycle.
interface exu_regalu_if #(
  parameter int XLEN   = 32,
  parameter int GPR_AW = 5,
  parameter int OPC_W  = 4
);
  logic [GPR_AW-1:0] gpr_raddr1;
  logic [XLEN-1:0]   gpr_rdata1;
  logic [GPR_AW-1:0] gpr_raddr2;
  logic [XLEN-1:0]   gpr_rdata2;
  logic [GPR_AW-1:0] gpr_waddr;
  logic [XLEN-1:0]   gpr_wdata;
  logic              gpr_wen;
  logic [OPC_W-1:0]  alu_opcode;
  logic [XLEN-1:0]   alu_src1;
  logic [XLEN-1:0]   alu_src2;
  logic [XLEN-1:0]   alu_dst;

  // Execute control FSM side
  modport master (
    output gpr_raddr1, gpr_raddr2, gpr_waddr, gpr_wdata, gpr_wen,
    output alu_opcode, alu_src1, alu_src2,
    input  gpr_rdata1, gpr_rdata2, alu_dst
  );

  // Datapath side
  modport slave (
    input  gpr_raddr1, gpr_raddr2, gpr_waddr, gpr_wdata, gpr_wen,
    input  alu_opcode, alu_src1, alu_src2,
    output gpr_rdata1, gpr_rdata2, alu_dst
  );
endinterface

// File: rtl/exu_regalu.sv
// GPR file (2 comb read, 1 sync write, x0 = 0) plus RV32I-style combinational ALU.
// Latency: reads and ALU zero-cycle; writes visible the cycle after the edge.
// Backpressure: none. Optional macro EXU_REGALU_WR_BYPASS_EN forwards same-cycle write data to reads.
module exu_regalu #(
  parameter int XLEN   = 32,
  parameter int GPR_AW = 5,
  parameter int OPC_W  = 4
) (
  input logic        clk,
  input logic        rst,
  exu_regalu_if.slave bus
);
  localparam int NREG = 1 << GPR_AW;
  localparam int SHW  = $clog2(XLEN);

  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_LTS = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_LTU = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_OR  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_AND = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_SLL = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_SRL = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_SRA = OPC_W'(9);

  // Entry 0 exists only to keep indexing simple; it is never read out.
  logic [XLEN-1:0] regs [NREG];
  logic [SHW-1:0]  shamt;

  // Register file update: async clear wins over any same-cycle write; x0 writes dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (bus.gpr_wen && (bus.gpr_waddr != '0)) begin
      regs[bus.gpr_waddr] <= bus.gpr_wdata;
    end
  end

  // Read port 1: x0 forced to zero, optional write forwarding.
  always_comb begin
    bus.gpr_rdata1 = (bus.gpr_raddr1 == '0) ? '0 : regs[bus.gpr_raddr1];
`ifdef EXU_REGALU_WR_BYPASS_EN
    if (bus.gpr_wen && (bus.gpr_raddr1 != '0) && (bus.gpr_waddr == bus.gpr_raddr1))
      bus.gpr_rdata1 = bus.gpr_wdata;
`endif
  end

  // Read port 2: same policy as port 1.
  always_comb begin
    bus.gpr_rdata2 = (bus.gpr_raddr2 == '0) ? '0 : regs[bus.gpr_raddr2];
`ifdef EXU_REGALU_WR_BYPASS_EN
    if (bus.gpr_wen && (bus.gpr_raddr2 != '0) && (bus.gpr_waddr == bus.gpr_raddr2))
      bus.gpr_rdata2 = bus.gpr_wdata;
`endif
  end

  // Only the low bits of src2 steer the shifters.
  assign shamt = bus.alu_src2[SHW-1:0];

  // ALU: unused opcodes return zero so no state is ever held.
  always_comb begin
    bus.alu_dst = '0;
    case (bus.alu_opcode)
      OP_ADD: bus.alu_dst = bus.alu_src1 + bus.alu_src2;
      OP_SUB: bus.alu_dst = bus.alu_src1 - bus.alu_src2;
      OP_LTS: bus.alu_dst = {{(XLEN-1){1'b0}}, ($signed(bus.alu_src1) < $signed(bus.alu_src2))};
      OP_LTU: bus.alu_dst = {{(XLEN-1){1'b0}}, (bus.alu_src1 < bus.alu_src2)};
      OP_XOR: bus.alu_dst = bus.alu_src1 ^ bus.alu_src2;
      OP_OR:  bus.alu_dst = bus.alu_src1 | bus.alu_src2;
      OP_AND: bus.alu_dst = bus.alu_src1 & bus.alu_src2;
      OP_SLL: bus.alu_dst = bus.alu_src1 << shamt;
      OP_SRL: bus.alu_dst = bus.alu_src1 >> shamt;
      OP_SRA: bus.alu_dst = $unsigned($signed(bus.alu_src1) >>> shamt);
      default: bus.alu_dst = '0;
    endcase
  end
endmodule

// File: tb/tb_exu_regalu.sv
// Testbench for exu_regalu: directed corner cases then random traffic against a reference model.
// Expected outputs are queued at stimulus time and checked by a negedge monitor.
// Build with +define+EXU_REGALU_WR_BYPASS_EN to exercise the forwarding variant.
module tb_exu_regalu;
  logic clk = 1'b0;
  logic rst = 1'b1;

  exu_regalu_if #(.XLEN(32), .GPR_AW(5), .OPC_W(4)) bus ();

  exu_regalu #(.XLEN(32), .GPR_AW(5), .OPC_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    int          sel;   // 0: rdata1, 1: rdata2, 2: alu_dst
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mregs [32];
  int          n_chk  = 0;
  int          n_fail = 0;

  // Architectural register read as seen by software.
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef EXU_REGALU_WR_BYPASS_EN
    if (bus.gpr_wen && (bus.gpr_waddr == a)) return bus.gpr_wdata;
`endif
    return mregs[a];
  endfunction

  // ALU reference written with plain integer arithmetic.
  function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint unsigned p2 = 64'd1 << b[4:0];
    int sa = a;
    int sbv = b;
    logic [31:0] na = ~a;
    case (op)
      0: return 32'((ua + ub) % 64'h1_0000_0000);
      1: return 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
      2: return (sa < sbv) ? 32'd1 : 32'd0;
      3: return (ua < ub) ? 32'd1 : 32'd0;
      4: return a ^ b;
      5: return a | b;
      6: return a & b;
      7: return 32'((ua * p2) % 64'h1_0000_0000);
      8: return 32'(ua / p2);
      9: return a[31] ? ~32'({32'd0, na} / p2) : 32'(ua / p2);
      default: return 32'd0;
    endcase
  endfunction

  task automatic push(input string nm, input int sel, input logic [31:0] v);
    exp_t e;
    e.nm = nm; e.sel = sel; e.val = v;
    sb.push_back(e);
  endtask

  // Queue expectations for current inputs, advance one edge, update the model.
  task automatic step(input string nm);
    push({nm, "_rd1"}, 0, exp_rd(bus.gpr_raddr1));
    push({nm, "_rd2"}, 1, exp_rd(bus.gpr_raddr2));
    push({nm, "_alu"}, 2, alu_ref(int'(bus.alu_opcode), bus.alu_src1, bus.alu_src2));
    @(posedge clk);
    if (!rst && bus.gpr_wen && (bus.gpr_waddr != 5'd0)) mregs[bus.gpr_waddr] = bus.gpr_wdata;
    #1;
  endtask

  task automatic set_wr(input logic en, input logic [4:0] a, input logic [31:0] d);
    bus.gpr_wen = en; bus.gpr_waddr = a; bus.gpr_wdata = d;
  endtask

  task automatic set_rd(input logic [4:0] a1, input logic [4:0] a2);
    bus.gpr_raddr1 = a1; bus.gpr_raddr2 = a2;
  endtask

  task automatic alu(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.alu_opcode = op; bus.alu_src1 = a; bus.alu_src2 = b;
    step(nm);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compare every queued expectation against the outputs mid-cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.sel)
        0: act = bus.gpr_rdata1;
        1: act = bus.gpr_rdata2;
        default: act = bus.alu_dst;
      endcase
      n_chk++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", e.nm, act, e.val, $time);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    set_wr(1'b0, 5'd0, 32'd0);
    set_rd(5'd0, 5'd0);
    bus.alu_opcode = 4'd0; bus.alu_src1 = 32'd0; bus.alu_src2 = 32'd0;
    @(posedge clk);
    #1;

    // Reset sweep of every address.
    for (int i = 0; i < 32; i += 2) begin
      set_rd(5'(i), 5'(i + 1));
      step("rst_sweep");
    end
    // Write during reset must be dropped.
    set_rd(5'd0, 5'd0);
    set_wr(1'b1, 5'd5, 32'hDEAD_BEEF);
    step("rst_wr");
    rst = 1'b0;
    set_wr(1'b0, 5'd0, 32'd0);
    set_rd(5'd5, 5'd5);
    step("rst_wr_x5");

    // Basic write/read and x0 hardwiring.
    set_wr(1'b1, 5'd3, 32'h1234_5678);
    set_rd(5'd0, 5'd0);
    step("wr_x3");
    set_wr(1'b1, 5'd0, 32'hFFFF_FFFF);
    set_rd(5'd3, 5'd0);
    step("wr_x0");
    set_wr(1'b0, 5'd0, 32'd0);
    set_rd(5'd3, 5'd0);
    step("rd_x3_x0");

    // Same-cycle write/read of x7.
    set_wr(1'b1, 5'd7, 32'd1);
    set_rd(5'd0, 5'd0);
    step("x7_init");
    set_wr(1'b1, 5'd7, 32'd2);
    set_rd(5'd7, 5'd7);
    step("x7_same_cyc");
    set_wr(1'b0, 5'd0, 32'd0);
    step("x7_after");

    // Async reset clears without an edge.
    set_wr(1'b1, 5'd9, 32'hA5A5_0F0F);
    set_rd(5'd0, 5'd0);
    step("x9_wr");
    set_wr(1'b0, 5'd0, 32'd0);
    set_rd(5'd9, 5'd3);
    step("x9_rd");
    rst = 1'b1;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    step("async_rst");
    rst = 1'b0;
    set_rd(5'd0, 5'd0);

    // Directed ALU corners.
    alu("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1);
    alu("sub_wrap", 4'd1, 32'd0, 32'd1);
    alu("lts", 4'd2, 32'h8000_0000, 32'd1);
    alu("ltu", 4'd3, 32'h8000_0000, 32'd1);
    alu("xor", 4'd4, 32'h0000_F0F0, 32'h0000_FF00);
    alu("or", 4'd5, 32'h0000_F0F0, 32'h0000_FF00);
    alu("and", 4'd6, 32'h0000_F0F0, 32'h0000_FF00);
    alu("sll_shamt", 4'd7, 32'd1, 32'h21);
    alu("srl", 4'd8, 32'h8000_0000, 32'd31);
    alu("sra", 4'd9, 32'h8000_0000, 32'd31);
    alu("sra_pos", 4'd9, 32'h4000_0000, 32'h3E);
    alu("illegal12", 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    alu("illegal15", 4'd15, 32'h1234_5678, 32'h1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      set_wr(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), rnd_val());
      if ($urandom_range(0, 3) == 0) set_rd(bus.gpr_waddr, 5'($urandom_range(0, 31)));
      else set_rd(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      bus.alu_opcode = 4'($urandom_range(0, 15));
      bus.alu_src1 = rnd_val();
      bus.alu_src2 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : rnd_val();
      step("rnd");
    end
    set_wr(1'b0, 5'd0, 32'd0);

    repeat (2) @(posedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
